traffic_conflict_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/lamp_flash_gen.sv | 36 +++
 rtl/traffic_conflict_monitor.sv | 141 ++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp-bus definitions for the traffic conflict monitor: lamp codes,
// approach slicing, fault causes and monitor state encoding.
package traffic_pkg;

  typedef enum logic [1:0] {
    LAMP_RED     = 2'b00,
    LAMP_YELLOW  = 2'b01,
    LAMP_GREEN   = 2'b10,
    LAMP_ILLEGAL = 2'b11
  } lamp_e;

  localparam int APP_WEST  = 0;
  localparam int APP_SOUTH = 1;
  localparam int APP_EAST  = 2;
  localparam int APP_NORTH = 3;
  localparam int NUM_APPROACHES = 4;

  typedef enum logic [2:0] {
    FLT_NONE        = 3'd0,
    FLT_INVALID     = 3'd1,
    FLT_CONFLICT    = 3'd2,
    FLT_SKIP_YELLOW = 3'd3,
    FLT_STUCK       = 3'd4
  } fault_e;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_ALLRED  = 2'd1,
    ST_FLASH   = 2'd2,
    ST_REARM   = 2'd3
  } mon_state_e;

  localparam logic [7:0] ALL_RED    = 8'h00;
  localparam logic [7:0] ALL_YELLOW = 8'h55;

  // Approach index 0 is west (bits 1:0), index 3 is north (bits 7:6).
  function automatic logic [1:0] lamp_of(input logic [7:0] bus, input int app);
    return bus[2*app +: 2];
  endfunction

  function automatic logic [3:0] lamp_mask(input logic [7:0] bus, input lamp_e code);
    logic [3:0] m;
    for (int i = 0; i < NUM_APPROACHES; i++) begin
      m[i] = (lamp_of(bus, i) == code);
    end
    return m;
  endfunction

endpackage

// File: rtl/lamp_flash_gen.sv
// Half-period divider for the fault flash pattern; held at phase 0 while idle.
module lamp_flash_gen #(
  parameter int unsigned FLASH_TICKS = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase,
  output logic wrap
);

  localparam int CW = $clog2(FLASH_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(FLASH_TICKS - 1);

  logic [CW-1:0] cnt;

  // wrap marks the last cycle of a half-period so the owner can update its
  // registered output in step with the phase flip.
  assign wrap = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!enable) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the board pins:
// passes legal lamp patterns through, forces all-red then flashing on a fault.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned FREQ          = 50000000,
  parameter int unsigned MAX_GREEN_SEC = 8,
  parameter int unsigned ALLRED_SEC    = 2,
  parameter int unsigned FLASH_TICKS   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lamp_in,
  input  logic       fault_clr,
  output logic [7:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam int unsigned GREEN_LIMIT   = MAX_GREEN_SEC * FREQ;
  localparam int unsigned ALLRED_CYCLES = ALLRED_SEC * FREQ;
  localparam int GW = $clog2(GREEN_LIMIT + 1);
  localparam int AW = $clog2(ALLRED_CYCLES + 1);
  localparam logic [GW-1:0] GREEN_MAX   = GW'(GREEN_LIMIT);
  localparam logic [AW-1:0] ALLRED_LAST = AW'(ALLRED_CYCLES - 1);

  mon_state_e    state;
  logic [7:0]    prev;
  logic [GW-1:0] green_cnt;
  logic [GW-1:0] green_nxt;
  logic [AW-1:0] allred_cnt;
  logic [3:0]    grn_in;
  logic [3:0]    grn_prev;
  logic [3:0]    red_in;
  logic          illegal_in;
  logic          clr_ok;
  logic          rearm_ok;
  logic          flash_phase;
  logic          flash_wrap;
  fault_e        viol;

  lamp_flash_gen #(
    .FLASH_TICKS(FLASH_TICKS)
  ) u_flash (
    .clk   (clk),
    .reset (reset),
    .enable(state == ST_FLASH),
    .phase (flash_phase),
    .wrap  (flash_wrap)
  );

  assign fault = (state != ST_MONITOR);

  // Violation checks in priority order; the green run length only continues
  // when the same single approach was the only green last cycle too.
  always_comb begin
    grn_in     = lamp_mask(lamp_in, LAMP_GREEN);
    grn_prev   = lamp_mask(prev, LAMP_GREEN);
    red_in     = lamp_mask(lamp_in, LAMP_RED);
    illegal_in = |lamp_mask(lamp_in, LAMP_ILLEGAL);
    clr_ok     = !illegal_in && $onehot0(grn_in);
    rearm_ok   = !illegal_in && (grn_in == 4'b0000);

    green_nxt = '0;
    if ($onehot(grn_in)) begin
      if (grn_in == grn_prev) begin
        green_nxt = (green_cnt == GREEN_MAX) ? green_cnt : green_cnt + 1'b1;
      end else begin
        green_nxt = GW'(1);
      end
    end

    viol = FLT_NONE;
    if (illegal_in) begin
      viol = FLT_INVALID;
    end else if (!$onehot0(grn_in)) begin
      viol = FLT_CONFLICT;
    end else if (|(grn_prev & red_in)) begin
      viol = FLT_SKIP_YELLOW;
    end else if (green_nxt == GREEN_MAX) begin
      viol = FLT_STUCK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_MONITOR;
      lamp_out   <= ALL_RED;
      prev       <= ALL_YELLOW;
      fault_code <= FLT_NONE;
      fault_cnt  <= '0;
      green_cnt  <= '0;
      allred_cnt <= '0;
    end else begin
      prev      <= lamp_in;
      green_cnt <= green_nxt;
      case (state)
        ST_MONITOR: begin
          if (viol != FLT_NONE) begin
            state      <= ST_ALLRED;
            lamp_out   <= ALL_RED;
            fault_code <= viol;
            allred_cnt <= '0;
            if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 1'b1;
          end else begin
            lamp_out <= lamp_in;
          end
        end
        ST_ALLRED: begin
          lamp_out <= ALL_RED;
          if (allred_cnt == ALLRED_LAST) begin
            state    <= ST_FLASH;
            lamp_out <= ALL_YELLOW;
          end else begin
            allred_cnt <= allred_cnt + 1'b1;
          end
        end
        ST_FLASH: begin
          // A refused clear is simply dropped; software must request again.
          if (fault_clr && clr_ok) begin
            state    <= ST_REARM;
            lamp_out <= ALL_RED;
          end else if (flash_wrap) begin
            lamp_out <= flash_phase ? ALL_YELLOW : ALL_RED;
          end
        end
        ST_REARM: begin
          lamp_out <= ALL_RED;
          if (rearm_ok) begin
            state      <= ST_MONITOR;
            fault_code <= FLT_NONE;
            green_cnt  <= '0;
          end
        end
        default: state <= ST_MONITOR;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Randomized and directed bench for traffic_conflict_monitor against a
// timeline-based reference model of the fault behaviour.
module tb_traffic_conflict_monitor;

  localparam int FREQ          = 10;
  localparam int MAX_GREEN_SEC = 2;
  localparam int ALLRED_SEC    = 1;
  localparam int FLASH_TICKS   = 3;
  localparam int GREEN_LIMIT   = MAX_GREEN_SEC * FREQ;
  localparam int ALLRED_CYCLES = ALLRED_SEC * FREQ;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lamp_in;
  logic       fault_clr;
  logic [7:0] lamp_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_cnt;

  int checks = 0;
  int errors = 0;
  string phase_name = "reset";

  logic [7:0] m_prev;
  logic [7:0] m_out;
  bit         m_fault;
  bit         m_rearm;
  int         m_t;
  int         m_code;
  int         m_cnt;
  int         m_run;

  logic [7:0] pats [10];
  logic [7:0] greens [4];
  logic [7:0] yellows [4];

  traffic_conflict_monitor #(
    .FREQ(FREQ),
    .MAX_GREEN_SEC(MAX_GREEN_SEC),
    .ALLRED_SEC(ALLRED_SEC),
    .FLASH_TICKS(FLASH_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lamp_in   (lamp_in),
    .fault_clr (fault_clr),
    .lamp_out  (lamp_out),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h at %0t",
               phase_name, tag, observed, expected, $time);
    end
  endtask

  function automatic int count_code(input logic [7:0] b, input logic [1:0] code);
    int n = 0;
    for (int i = 0; i < 4; i++) if (b[2*i +: 2] == code) n++;
    return n;
  endfunction

  function automatic int green_pos(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (b[2*i +: 2] == 2'b10) return i;
    return -1;
  endfunction

  // Expected lamps t cycles after the fault was taken: all-red, then flashing.
  function automatic logic [7:0] fault_pattern(input int t);
    if (t < ALLRED_CYCLES) return 8'h00;
    return (((t - ALLRED_CYCLES) / FLASH_TICKS) % 2 == 0) ? 8'h55 : 8'h00;
  endfunction

  task automatic model_reset();
    m_prev = 8'h55; m_out = 8'h00; m_fault = 0; m_rearm = 0;
    m_t = 0; m_code = 0; m_cnt = 0; m_run = 0;
  endtask

  task automatic model_step(input logic [7:0] lamp, input logic clr);
    int  g_now, g_prev, run_nxt, code;
    bit  bad, skip;
    g_now  = count_code(lamp, 2'b10);
    g_prev = count_code(m_prev, 2'b10);
    bad    = count_code(lamp, 2'b11) != 0;
    skip   = 0;
    for (int i = 0; i < 4; i++)
      if (m_prev[2*i +: 2] == 2'b10 && lamp[2*i +: 2] == 2'b00) skip = 1;
    if (g_now == 1 && g_prev == 1 && green_pos(lamp) == green_pos(m_prev))
      run_nxt = (m_run >= GREEN_LIMIT) ? GREEN_LIMIT : m_run + 1;
    else
      run_nxt = (g_now == 1) ? 1 : 0;

    if (!m_fault) begin
      code = bad ? 1 : (g_now >= 2) ? 2 : skip ? 3 : (run_nxt >= GREEN_LIMIT) ? 4 : 0;
      if (code != 0) begin
        m_fault = 1; m_t = 0; m_out = 8'h00; m_code = code;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_out = lamp;
      end
    end else if (!m_rearm) begin
      if (m_t >= ALLRED_CYCLES && clr && !bad && g_now <= 1) begin
        m_rearm = 1; m_out = 8'h00;
      end else begin
        m_t++; m_out = fault_pattern(m_t);
      end
    end else begin
      m_out = 8'h00;
      if (g_now == 0 && !bad) begin
        m_fault = 0; m_rearm = 0; m_code = 0;
      end
    end
    m_prev = lamp;
    m_run  = run_nxt;
  endtask

  task automatic applyStimulus(input logic [7:0] lamp, input logic clr);
    lamp_in   = lamp;
    fault_clr = clr;
    @(posedge clk);
    model_step(lamp, clr);
    #1;
    checkOutput("lamp_out", 32'(lamp_out), 32'(m_out));
    checkOutput("fault", 32'(fault), 32'(m_fault));
    checkOutput("fault_code", 32'(fault_code), 32'(m_code));
    checkOutput("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
  endtask

  task automatic recover();
    repeat (ALLRED_CYCLES) applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0);
  endtask

  task automatic legal_cycle();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 15)) applyStimulus(greens[k], 1'b0);
      repeat ($urandom_range(1, 3)) applyStimulus(yellows[k], 1'b0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  lamp;
    pats = '{8'h00, 8'h55, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    greens  = '{8'h80, 8'h20, 8'h08, 8'h02};
    yellows = '{8'h40, 8'h10, 8'h04, 8'h01};

    reset = 1'b0; lamp_in = 8'h55; fault_clr = 1'b0;
    model_reset();
    #3;
    checkOutput("lamp_out", 32'(lamp_out), 32'h00);
    checkOutput("fault", 32'(fault), 32'h0);
    checkOutput("fault_code", 32'(fault_code), 32'h0);
    checkOutput("fault_cnt", 32'(fault_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    phase_name = "legal";
    repeat (2) legal_cycle();

    phase_name = "conflict";
    applyStimulus(8'hA0, 1'b0);
    checkOutput("code_conflict", 32'(fault_code), 32'd2);
    repeat (ALLRED_CYCLES) applyStimulus(8'h00, 1'b1);
    checkOutput("flash_start", 32'(lamp_out), 32'h55);
    repeat (12) applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h80, 1'b1);
    repeat (2) applyStimulus(8'h80, 1'b0);
    applyStimulus(8'h55, 1'b0);
    checkOutput("rearm_fault", 32'(fault), 32'h0);
    checkOutput("rearm_cnt", 32'(fault_cnt), 32'd1);

    phase_name = "stuck";
    repeat (GREEN_LIMIT - 1) applyStimulus(8'h80, 1'b0);
    checkOutput("before_limit", 32'(fault), 32'h0);
    applyStimulus(8'h80, 1'b0);
    checkOutput("code_stuck", 32'(fault_code), 32'd4);
    recover();

    phase_name = "skip";
    repeat (3) applyStimulus(8'h80, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("code_skip", 32'(fault_code), 32'd3);
    recover();

    phase_name = "priority";
    applyStimulus(8'hE8, 1'b0);
    repeat (14) applyStimulus(8'hA0, 1'b0);
    checkOutput("code_sticky", 32'(fault_code), 32'd1);
    applyStimulus(8'hA0, 1'b1);
    checkOutput("clr_dropped", 32'(fault), 32'h1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0);

    phase_name = "random";
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        lamp = pats[$urandom_range(0, 9)];
      end else begin
        r = $urandom();
        lamp = r[7:0];
      end
      applyStimulus(lamp, $urandom_range(0, 3) == 0);
    end

    phase_name = "async_reset";
    repeat (15) applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    repeat (12) applyStimulus(8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checkOutput("lamp_out", 32'(lamp_out), 32'h00);
    checkOutput("fault", 32'(fault), 32'h0);
    checkOutput("fault_code", 32'(fault_code), 32'h0);
    checkOutput("fault_cnt", 32'(fault_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    phase_name = "saturate";
    for (int n = 0; n < 256; n++) begin
      applyStimulus(8'hFF, 1'b0);
      recover();
    end
    checkOutput("cnt_saturated", 32'(fault_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
